// File: rtl/pmu_ahb_cnt.sv
// AHB-Lite slave exposing N_COUNTERS event counters, sticky overflow flags and a masked IRQ.
// Build option: define PMU_AHB_ERR_RESP_EN to answer out-of-range accesses with a two-cycle ERROR.
module pmu_ahb_cnt #(
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32,
    parameter int N_COUNTERS  = 4,
    parameter int N_REGS      = N_COUNTERS + 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   hsel_i,
    input  logic                   hwrite_i,
    input  logic                   hreadyi_i,
    input  logic                   hmastlock_i,
    input  logic [HADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]             htrans_i,
    input  logic [2:0]             hsize_i,
    input  logic [2:0]             hburst_i,
    input  logic [3:0]             hprot_i,
    input  logic [3:0]             hmaster_i,
    input  logic [HDATA_WIDTH-1:0] hwdata_i,
    output logic                   hreadyo_o,
    output logic [1:0]             hresp_o,
    output logic [HDATA_WIDTH-1:0] hrdata_o,
    output logic [15:0]            hsplit_o,
    input  logic [N_COUNTERS-1:0]  events_i,
    output logic                   intr_o
);
    localparam int IW = $clog2(N_REGS);
    localparam int NB = HDATA_WIDTH / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
    state_t state_q, state_d;

    logic [IW-1:0]          idx_q;
    logic [LW-1:0]          alo_q;
    logic [2:0]             size_q;
    logic                   wr_q;
    logic                   rng_q;
    logic                   en_q;
    logic [N_COUNTERS-1:0]  mask_q;
    logic [N_COUNTERS-1:0]  ovf_q;
    logic [N_COUNTERS-1:0]  ovf_d;
    logic [N_COUNTERS-1:0]  ovf_set;
    logic [N_COUNTERS-1:0]  cnt_wr;
    logic [N_COUNTERS-1:0]  cnt_inc;
    logic [HDATA_WIDTH-1:0] cnt_q [N_COUNTERS];
    logic                   intr_q;

    logic                   accept;
    logic                   in_range;
    logic                   data_ph;
    logic                   wr_en;
    logic                   wr_ctrl;
    logic                   wr_ovf;
    logic                   clr;
    logic [HDATA_WIDTH-1:0] rd_val;
    logic [HDATA_WIDTH-1:0] bmask;
    logic [HDATA_WIDTH-1:0] wmerged;
    int                     lane_sz;

    logic unused_in;
    assign unused_in = ^{hmastlock_i, hburst_i, hprot_i, hmaster_i, htrans_i[0], haddr_i};

    // no new address phase is taken while the first ERROR cycle stalls the bus
    assign accept   = hsel_i & hreadyi_i & htrans_i[1] & (state_q != ST_ERR1);
    assign in_range = int'(haddr_i[IW+1:2]) < N_REGS;

    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
`ifdef PMU_AHB_ERR_RESP_EN
            state_d = in_range ? ST_DATA : ST_ERR1;
`else
            state_d = ST_DATA;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            alo_q   <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q  <= haddr_i[IW+1:2];
                alo_q  <= haddr_i[LW-1:0];
                size_q <= hsize_i;
                wr_q   <= hwrite_i;
                rng_q  <= in_range;
            end
        end
    end

    assign data_ph   = (state_q == ST_DATA) & rng_q;
    assign hreadyo_o = (state_q != ST_ERR1);
    assign hresp_o   = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign hsplit_o  = '0;
    assign intr_o    = intr_q;

    always_comb begin
        rd_val = '0;
        if (int'(idx_q) == 0) begin
            rd_val[0]              = en_q;
            rd_val[N_COUNTERS+1:2] = mask_q;
        end else if (int'(idx_q) == 1) begin
            rd_val[N_COUNTERS-1:0] = ovf_q;
        end
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (int'(idx_q) == i + 2) rd_val = cnt_q[i];
        end
    end

    assign hrdata_o = (data_ph & ~wr_q) ? rd_val : '0;

    // a lane is written when it shares the size-aligned block that the address points into
    always_comb begin
        lane_sz = (int'(size_q) > LW) ? LW : int'(size_q);
        bmask   = '0;
        for (int b = 0; b < NB; b++) begin
            if ((b >> lane_sz) == (int'(alo_q) >> lane_sz)) bmask[b*8 +: 8] = 8'hFF;
        end
    end

    assign wmerged = (hwdata_i & bmask) | (rd_val & ~bmask);
    assign wr_en   = data_ph & wr_q;
    assign wr_ctrl = wr_en & (int'(idx_q) == 0);
    assign wr_ovf  = wr_en & (int'(idx_q) == 1);
    assign clr     = wr_ctrl & wmerged[1];

    always_comb begin
        cnt_wr  = '0;
        cnt_inc = '0;
        ovf_set = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_wr[i]  = wr_en & (int'(idx_q) == i + 2);
            cnt_inc[i] = en_q & events_i[i] & ~cnt_wr[i];
            ovf_set[i] = cnt_inc[i] & (&cnt_q[i]);
        end
        ovf_d = (ovf_q & ~(wr_ovf ? (hwdata_i[N_COUNTERS-1:0] & bmask[N_COUNTERS-1:0])
                                   : '0)) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q   <= 1'b0;
            mask_q <= '0;
            intr_q <= 1'b0;
        end else begin
            intr_q <= |(ovf_q & mask_q);
            if (wr_ctrl) begin
                en_q   <= wmerged[0];
                mask_q <= wmerged[N_COUNTERS+1:2];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= '0;
            for (int i = 0; i < N_COUNTERS; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            ovf_q <= '0;
            for (int i = 0; i < N_COUNTERS; i++) cnt_q[i] <= '0;
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (cnt_wr[i])       cnt_q[i] <= wmerged;
                else if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

endmodule
